// File: rtl/neuron_accumulator.sv
// Saturating signed accumulator: sums a stream of product terms, adds a per-vector bias,
// optionally applies ReLU, and hands one result per vector over valid/ready.
module neuron_accumulator #(
    parameter int unsigned IN_W  = 20,
    parameter int unsigned ACC_W = 22,
    parameter int unsigned CNT_W = 10
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_in_valid,
    output logic                    o_in_ready,
    input  logic signed [IN_W-1:0]  i_in_data,
    input  logic                    i_in_last,
    input  logic signed [ACC_W-1:0] i_bias,
    input  logic                    i_relu_en,
    output logic                    o_out_valid,
    input  logic                    i_out_ready,
    output logic signed [ACC_W-1:0] o_out_data,
    output logic                    o_out_ovf,
    output logic [CNT_W-1:0]        o_out_count
);

    localparam logic [1:0] S_ACC   = 2'd0;
    localparam logic [1:0] S_FINAL = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [1:0]              r_state;
    logic signed [ACC_W-1:0] r_acc;
    logic                    r_ovf;
    logic [CNT_W-1:0]        r_cnt;
    logic signed [ACC_W-1:0] r_bias;
    logic                    r_relu;
    logic signed [ACC_W-1:0] r_out_data;
    logic                    r_out_ovf;
    logic [CNT_W-1:0]        r_out_count;

    logic [ACC_W:0]          w_sum_in;
    logic [ACC_W:0]          w_sum_bias;
    logic                    w_acc_clip;
    logic                    w_res_clip;
    logic [ACC_W-1:0]        w_acc_sat;
    logic [ACC_W-1:0]        w_res_sat;
    logic [ACC_W-1:0]        w_res;

    // One guard bit: top two bits disagreeing means the ACC_W-bit result overflowed.
    assign w_sum_in   = {r_acc[ACC_W-1], r_acc}
                      + {{(ACC_W+1-IN_W){i_in_data[IN_W-1]}}, i_in_data};
    assign w_sum_bias = {r_acc[ACC_W-1], r_acc} + {r_bias[ACC_W-1], r_bias};

    assign w_acc_clip = w_sum_in[ACC_W] ^ w_sum_in[ACC_W-1];
    assign w_res_clip = w_sum_bias[ACC_W] ^ w_sum_bias[ACC_W-1];

    assign w_acc_sat = w_acc_clip ? (w_sum_in[ACC_W] ? ACC_MIN : ACC_MAX)
                                  : w_sum_in[ACC_W-1:0];
    assign w_res_sat = w_res_clip ? (w_sum_bias[ACC_W] ? ACC_MIN : ACC_MAX)
                                  : w_sum_bias[ACC_W-1:0];
    assign w_res     = (r_relu && w_res_sat[ACC_W-1]) ? '0 : w_res_sat;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_ACC;
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_cnt       <= '0;
            r_bias      <= '0;
            r_relu      <= 1'b0;
            r_out_data  <= '0;
            r_out_ovf   <= 1'b0;
            r_out_count <= '0;
        end else begin
            case (r_state)
                S_ACC: begin
                    if (i_in_valid) begin
                        r_acc <= w_acc_sat;
                        r_ovf <= r_ovf | w_acc_clip;
                        if (r_cnt != {CNT_W{1'b1}}) begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                        if (i_in_last) begin
                            r_bias  <= i_bias;
                            r_relu  <= i_relu_en;
                            r_state <= S_FINAL;
                        end
                    end
                end
                S_FINAL: begin
                    r_out_data  <= w_res;
                    r_out_ovf   <= r_ovf | w_res_clip;
                    r_out_count <= r_cnt;
                    r_state     <= S_HOLD;
                end
                S_HOLD: begin
                    if (i_out_ready) begin
                        r_acc   <= '0;
                        r_ovf   <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= S_ACC;
                    end
                end
                default: r_state <= S_ACC;
            endcase
        end
    end

    assign o_in_ready  = (r_state == S_ACC);
    assign o_out_valid = (r_state == S_HOLD);
    assign o_out_data  = r_out_data;
    assign o_out_ovf   = r_out_ovf;
    assign o_out_count = r_out_count;

endmodule
